// File: rtl/line_buffer3.sv
// -----------------------------------------------------------------------------
// line_buffer3
//   Upstream stage of the 3x3 convolution block. Accepts a raster-order pixel
//   stream, one pixel per accepted beat, and keeps the two previous image rows
//   in line memories. For every accepted pixel from row 2 onward it emits one
//   vertical column triple (row r-2, r-1, r at the same column).
//
// Ports
//   clk        : single clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   in_pixel   : raster pixel
//   in_valid   : in_pixel valid
//   in_sof     : marks the beat as frame pixel (0,0); also a resync marker
//   in_ready   : block accepts a beat this cycle
//   pix_top    : pixel (row r-2, col c)
//   pix_mid    : pixel (row r-1, col c)
//   pix_bot    : pixel (row r,   col c)
//   out_valid  : triple valid
//   out_ready  : downstream accepts the triple
//   out_sol    : triple is column 0
//   out_eol    : triple is column IMG_WIDTH-1
//   out_eof    : triple is the last one of the frame
//   sync_err   : one-cycle pulse, in_sof accepted while position != (0,0)
// -----------------------------------------------------------------------------
module line_buffer3 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sol,
  output logic                   out_eol,
  output logic                   out_eof,
  output logic                   sync_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_EMIT  = ROW_W'(2);

  // Position of the next accepted pixel.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Output register.
  logic                   out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0] top_q, top_d;
  logic [PIXEL_WIDTH-1:0] mid_q, mid_d;
  logic [PIXEL_WIDTH-1:0] bot_q, bot_d;
  logic                   sol_q, sol_d;
  logic                   eol_q, eol_d;
  logic                   eof_q, eof_d;
  logic                   sync_err_q, sync_err_d;

  // L0 holds row r-2, L1 holds row r-1, both indexed by column.
  logic [PIXEL_WIDTH-1:0] l0_mem [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] l1_mem [IMG_WIDTH];

  logic                   accept;
  logic                   load_out;
  logic [COL_W-1:0]       pos_col;
  logic [ROW_W-1:0]       pos_row;
  logic [PIXEL_WIDTH-1:0] old_l0;
  logic [PIXEL_WIDTH-1:0] old_l1;

  // Single output register without skid: a new beat is taken only when the
  // register is empty or is being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // An accepted in_sof forces the beat to (0,0) whatever the counters say.
  assign pos_col = in_sof ? '0 : col_q;
  assign pos_row = in_sof ? '0 : row_q;

  // Asynchronous reads give the pre-write contents for this column.
  assign old_l0 = l0_mem[pos_col];
  assign old_l1 = l1_mem[pos_col];

  // Rows 0 and 1 only prime the memories. Because the next frame starts by
  // rewriting both rows, stale data can never be paired into a triple.
  assign load_out = accept && (pos_row >= ROW_EMIT);

  // NOTE: every comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    sol_d       = sol_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    sync_err_d  = 1'b0;

    if (accept) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      sync_err_d = in_sof && ((col_q != '0) || (row_q != '0));
    end

    // A load in the same cycle as a handshake keeps out_valid high.
    if (load_out) begin
      out_valid_d = 1'b1;
      top_d       = old_l0;
      mid_d       = old_l1;
      bot_d       = in_pixel;
      sol_d       = (pos_col == '0);
      eol_d       = (pos_col == COL_LAST);
      eof_d       = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      sol_q       <= sol_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // NOTE: line memories are deliberately left out of reset; their contents
  // are always rewritten before use, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (accept) begin
      l0_mem[pos_col] <= old_l1;
      l1_mem[pos_col] <= in_pixel;
    end
  end

  assign out_valid = out_valid_q;
  assign pix_top   = top_q;
  assign pix_mid   = mid_q;
  assign pix_bot   = bot_q;
  assign out_sol   = sol_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_line_buffer3.sv
// -----------------------------------------------------------------------------
// tb_line_buffer3
//   Self-checking bench for line_buffer3 with a 4x4 image. A table of per-cycle
//   vectors covers frame priming; hand-written sequences cover backpressure,
//   back-to-back frames, resync, mid-frame reset and random bubbles, with a
//   scoreboard of expected triples derived from each pixel's raster index.
// -----------------------------------------------------------------------------
module tb_line_buffer3;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] in_pixel;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic [PW-1:0] pix_top, pix_mid, pix_bot;
  logic          out_valid;
  logic          out_ready;
  logic          out_sol, out_eol, out_eof;
  logic          sync_err;

  line_buffer3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .pix_top   (pix_top),
    .pix_mid   (pix_mid),
    .pix_bot   (pix_bot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sol   (out_sol),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] t;
    logic [PW-1:0] m;
    logic [PW-1:0] b;
    logic          sol;
    logic          eol;
    logic          eof;
  } trip_t;

  typedef struct {
    logic [PW-1:0] pix;
    logic          v;
    logic          sof;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    trip_t         e_trip;
    logic          e_sync;
  } vec_t;

  int    checks   = 0;
  int    errors   = 0;
  int    sync_cnt = 0;
  int    pops     = 0;
  trip_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic trip_t cur_trip();
    return '{t: pix_top, m: pix_mid, b: pix_bot, sol: out_sol, eol: out_eol, eof: out_eof};
  endfunction

  // Expected triple for the pixel at raster index k of a frame whose pixels are base+k.
  function automatic trip_t model_trip(input int base, input int k);
    return '{t: PW'(base + k - 2*W), m: PW'(base + k - W), b: PW'(base + k),
             sol: (k % W == 0), eol: (k % W == W-1), eof: (k == NPIX-1)};
  endfunction

  // One clock cycle: drive, sample before the edge, score any handshake, advance.
  task automatic cycle(input logic v, input logic [PW-1:0] p, input logic s,
                       input logic r, output logic acc);
    trip_t e;
    in_valid  = v;
    in_pixel  = p;
    in_sof    = s;
    out_ready = r;
    #1;
    acc = v && in_ready;
    if (sync_err) sync_cnt++;
    if (out_valid && r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_triple", 32'(cur_trip()), 32'h0);
      end else begin
        e = exp_q.pop_front();
        pops++;
        check("triple", 32'(cur_trip()), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send pixel k of a frame until accepted; record the expected triple.
  task automatic feed(input int base, input int k, input logic sof, input logic bubble);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      if (bubble)
        cycle(1'($urandom_range(0, 1)), PW'(base + k), sof, 1'($urandom_range(0, 1)), acc);
      else
        cycle(1'b1, PW'(base + k), sof, 1'b1, acc);
      tries++;
    end
    if (!acc) check("feed_timeout", 32'(tries), 32'h0);
    else if (k >= 2*W) exp_q.push_back(model_trip(base, k));
  endtask

  task automatic feed_frame(input int base, input logic bubble);
    for (int k = 0; k < NPIX; k++) feed(base, k, (k == 0), bubble);
  endtask

  task automatic drain(input logic bubble);
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      cycle(1'b0, '0, 1'b0, bubble ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    check("drain_out_valid", 32'(out_valid), 32'h0);
  endtask

  vec_t vecs[NPIX + 1];

  initial begin
    logic acc;
    int   pops0;
    int   sync0;

    for (int k = 0; k <= NPIX; k++) begin
      vecs[k].pix    = PW'(k);
      vecs[k].v      = (k < NPIX);
      vecs[k].sof    = (k == 0);
      vecs[k].ordy   = 1'b1;
      vecs[k].e_rdy  = 1'b1;
      vecs[k].e_ov   = (k >= 2*W) && (k < NPIX);
      vecs[k].e_trip = model_trip(0, k);
      vecs[k].e_sync = 1'b0;
    end

    rst       = 1'b1;
    in_pixel  = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_triple", 32'(cur_trip()), 32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'h1);

    // Test 1: priming, table driven.
    for (int k = 0; k <= NPIX; k++) begin
      in_valid  = vecs[k].v;
      in_pixel  = vecs[k].pix;
      in_sof    = vecs[k].sof;
      out_ready = vecs[k].ordy;
      #1;
      check($sformatf("t1_in_ready[%0d]", k), 32'(in_ready), 32'(vecs[k].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("t1_out_valid[%0d]", k), 32'(out_valid), 32'(vecs[k].e_ov));
      if (vecs[k].e_ov)
        check($sformatf("t1_triple[%0d]", k), 32'(cur_trip()), 32'(vecs[k].e_trip));
      check($sformatf("t1_sync[%0d]", k), 32'(sync_err), 32'(vecs[k].e_sync));
    end

    // Test 2: backpressure while the first triple is pending.
    for (int k = 0; k <= 2*W; k++) feed(0, k, (k == 0), 1'b0);
    check("t2_first_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, PW'(2*W + 1), 1'b0, 1'b0, acc);
      check("t2_bp_accept", 32'(acc), 32'h0);
      check("t2_bp_valid", 32'(out_valid), 32'h1);
      check("t2_bp_hold", 32'(cur_trip()), 32'(model_trip(0, 2*W)));
    end
    for (int k = 2*W + 1; k < NPIX; k++) feed(0, k, 1'b0, 1'b0);
    drain(1'b0);

    // Test 3: back-to-back frames.
    pops0 = pops;
    feed_frame(0, 1'b0);
    feed_frame(100, 1'b0);
    drain(1'b0);
    check("t3_triple_count", 32'(pops - pops0), 32'(2 * (H-2) * W));

    // Test 4: resync on the 7th accepted pixel.
    sync0 = sync_cnt;
    for (int k = 0; k < 6; k++) feed(0, k, (k == 0), 1'b0);
    feed(50, 0, 1'b1, 1'b0);
    check("t4_sync_pulse", 32'(sync_err), 32'h1);
    feed(50, 1, 1'b0, 1'b0);
    check("t4_sync_clear", 32'(sync_err), 32'h0);
    for (int k = 2; k < 2*W; k++) feed(50, k, 1'b0, 1'b0);
    check("t4_no_early_out", 32'(out_valid), 32'h0);
    feed(50, 2*W, 1'b0, 1'b0);
    check("t4_first_out", 32'(out_valid), 32'h1);
    check("t4_first_trip", 32'(cur_trip()), 32'(model_trip(50, 2*W)));
    for (int k = 2*W + 1; k < NPIX; k++) feed(50, k, 1'b0, 1'b0);
    drain(1'b0);
    check("t4_sync_count", 32'(sync_cnt - sync0), 32'h1);

    // Test 5: reset after 10 pixels.
    for (int k = 0; k < 10; k++) feed(0, k, (k == 0), 1'b0);
    check("t5_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'h0);
    check("t5_async_triple", 32'(cur_trip()), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t5_rel_ready", 32'(in_ready), 32'h1);
    pops0 = pops;
    feed_frame(0, 1'b0);
    drain(1'b0);
    check("t5_triple_count", 32'(pops - pops0), 32'((H-2) * W));

    // Test 6: random input bubbles and random downstream stalls.
    pops0 = pops;
    feed_frame(0, 1'b1);
    drain(1'b1);
    check("t6_triple_count", 32'(pops - pops0), 32'((H-2) * W));

    check("total_sync_pulses", 32'(sync_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
